// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader in front of the single-cycle RISC-V core.
//   Consumes a length-prefixed byte stream (16-bit word count, low byte
//   first, then 4*N little-endian word bytes). It packs each group of four
//   bytes into a 32-bit word and writes it to instruction memory at
//   consecutive word addresses. The core is held in reset until the last
//   word is written.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   in_valid      in_data carries a byte
//   in_data[7:0]  stream byte
//   in_ready      loader accepts a byte this cycle (HDR0/HDR1/DATA)
//   reload        one-cycle pulse, restarts loading from DONE
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word address of the current write
//   imem_wdata    instruction word being written
//   core_reset    processor reset, high unless in DONE
//   load_done     high in DONE
//   load_error    high in ERROR (only reset leaves it)
//   words_loaded  words written since the load started
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  // Memory capacity in words; 17 bits so 2^16 is still representable.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         buf_q, buf_d;
  logic [15:0]         words_q, words_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                accept;
  logic [15:0]         hdr_count;
  logic [15:0]         words_inc;

  assign in_ready  = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA);
  assign accept    = in_valid && in_ready;
  // Full word count as it will look once the high byte is latched.
  assign hdr_count = {in_data, count_q[7:0]};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    count_d = count_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_HDR0: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = S_HDR1;
        end
      end

      S_HDR1: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if (hdr_count == 16'd0)              state_d = S_DONE;
          else if ({1'b0, hdr_count} > CAPACITY) state_d = S_ERROR;
          else                                 state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // Lane 3 completes the word: the three buffered bytes form the
            // low 24 bits, the byte arriving now is the top byte.
            we_d    = 1'b1;
            addr_d  = ADDR_W'(words_q);
            wdata_d = {in_data, buf_q};
            words_d = words_inc;
            if (words_inc == count_q) state_d = S_DONE;
          end else begin
            // Shift right so the first byte ends up in buf_q[7:0].
            buf_d = {in_data, buf_q[23:8]};
          end
        end
      end

      S_DONE: begin
        if (reload) begin
          state_d = S_HDR0;
          words_d = 16'd0;
          lane_d  = 2'd0;
        end
      end

      S_ERROR: ;

      default: state_d = S_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create ordering races.
    if (reset) begin
      state_q <= S_HDR0;
      count_q <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_reset   = (state_q != S_DONE);
  assign load_done    = (state_q == S_DONE);
  assign load_error   = (state_q == S_ERROR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: program load, gapped input, empty
// program, oversize count, mid-load reset, reset racing a word completion,
// and reload from DONE.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_error;
  logic [15:0]       words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed writes, sampled 1 time unit after each rising edge.
  int unsigned wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one byte for one cycle; optional random idle cycles before it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  // Drop in_valid at the next falling edge (one cycle after the last byte).
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_we"},    32'(imem_we), 32'd0);
    check({tag, "_addr"},  32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_crst"},  32'(core_reset), 32'd1);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_err"},   32'(load_error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  logic [7:0] prog2 [10];
  logic [7:0] prog3_head [8];

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00};
    prog3_head = '{8'h03, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};

    // ---- reset state ----
    do_reset();
    check_reset_values("rst");

    // ---- program load at full rate ----
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 10; i++) begin
      send_byte(prog2[i], 1'b0);
      if (i == 9) check("load_crst_before_last", 32'(core_reset), 32'd1);
    end
    idle();
    check("load_we_final",    32'(imem_we), 32'd1);
    check("load_addr_final",  32'(imem_addr), 32'd1);
    check("load_wdata_final", imem_wdata, 32'h0020_0593);
    check("load_done",        32'(load_done), 32'd1);
    check("load_crst",        32'(core_reset), 32'd0);
    check("load_ready",       32'(in_ready), 32'd0);
    check("load_words",       32'(words_loaded), 32'd2);
    @(negedge clk);
    check("load_we_drop",     32'(imem_we), 32'd0);
    check("load_nwr",         32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("load_a0", wr_addr[0], 32'd0);
      check("load_d0", wr_data[0], 32'h0010_0513);
      check("load_a1", wr_addr[1], 32'd1);
      check("load_d1", wr_data[1], 32'h0020_0593);
    end

    // ---- gapped input, same program ----
    do_reset();
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 10; i++) send_byte(prog2[i], 1'b1);
    idle();
    repeat (2) @(negedge clk);
    check("gap_nwr",   32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("gap_a0", wr_addr[0], 32'd0);
      check("gap_d0", wr_data[0], 32'h0010_0513);
      check("gap_a1", wr_addr[1], 32'd1);
      check("gap_d1", wr_data[1], 32'h0020_0593);
    end
    check("gap_done",  32'(load_done), 32'd1);
    check("gap_words", 32'(words_loaded), 32'd2);

    // ---- empty program ----
    do_reset();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle();
    check("empty_done",  32'(load_done), 32'd1);
    check("empty_crst",  32'(core_reset), 32'd0);
    check("empty_we",    32'(imem_we), 32'd0);
    check("empty_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("empty_nwr",   32'(wr_addr.size()), 32'd0);

    // ---- oversize count 0x0401 ----
    do_reset();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    idle();
    check("ovr_err",   32'(load_error), 32'd1);
    check("ovr_ready", 32'(in_ready), 32'd0);
    check("ovr_crst",  32'(core_reset), 32'd1);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
    check("ovr_reload_err",   32'(load_error), 32'd1);
    check("ovr_reload_ready", 32'(in_ready), 32'd0);
    check("ovr_nwr",          32'(wr_addr.size()), 32'd0);
    do_reset();
    check("ovr_rst_err",   32'(load_error), 32'd0);
    check("ovr_rst_ready", 32'(in_ready), 32'd1);

    // ---- capacity boundary: count 0x0400 is accepted ----
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    idle();
    check("cap_err",   32'(load_error), 32'd0);
    check("cap_ready", 32'(in_ready), 32'd1);

    // ---- mid-load reset after 6 data bytes of a 3-word program ----
    do_reset();
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 8; i++) send_byte(prog3_head[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("mid");
    check("mid_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("mid_a0", wr_addr[0], 32'd0);
      check("mid_d0", wr_data[0], 32'h0010_0513);
    end

    // ---- reset coinciding with a lane-3 accept suppresses the write ----
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("race_we",    32'(imem_we), 32'd0);
    check("race_words", 32'(words_loaded), 32'd0);
    check("race_crst",  32'(core_reset), 32'd1);
    @(negedge clk);
    check("race_nwr",   32'(wr_addr.size()), 32'd0);

    // ---- fresh full stream after reset loads from address 0 ----
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 10; i++) send_byte(prog2[i], 1'b0);
    idle();
    @(negedge clk);
    check("fresh_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("fresh_a0", wr_addr[0], 32'd0);
      check("fresh_d1", wr_data[1], 32'h0020_0593);
    end
    check("fresh_done", 32'(load_done), 32'd1);

    // ---- reload from DONE and load a one-word program ----
    wr_addr.delete(); wr_data.delete();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("rl_crst",  32'(core_reset), 32'd1);
    check("rl_ready", 32'(in_ready), 32'd1);
    check("rl_words", 32'(words_loaded), 32'd0);
    check("rl_done",  32'(load_done), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h73, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle();
    check("rl_we",    32'(imem_we), 32'd1);
    check("rl_addr",  32'(imem_addr), 32'd0);
    check("rl_wdata", imem_wdata, 32'h0000_0073);
    check("rl_crst_rel", 32'(core_reset), 32'd0);
    check("rl_done_set", 32'(load_done), 32'd1);
    check("rl_words_1",  32'(words_loaded), 32'd1);
    @(negedge clk);
    check("rl_nwr", 32'(wr_addr.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the 64-bit single-cycle RISC-V core. It receives a length-prefixed byte stream over a valid/ready handshake, packs the bytes into little-endian 32-bit instruction words and writes them into instruction memory at consecutive word addresses. It holds the core in reset until the whole program is written, then releases it.

## Interface
- ADDR_W, 10: instruction-memory word-address width; capacity is 2^ADDR_W words.
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  one-cycle pulse; restarts loading from DONE.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the current write.
- imem_wdata  output  32  instruction word being written.
- core_reset  output  1  reset to the processor core; high while loading.
- load_done  output  1  high in DONE.
- load_error  output  1  high in ERROR (sticky until reset).
- words_loaded  output  16  number of words written so far.

## Operation
- A byte is accepted only on a cycle with in_valid && in_ready; in_data is ignored on all other cycles.
- Stream format: 16-bit word count N, low byte first; then 4·N bytes, each word little-endian (first byte is wdata[7:0]).
- States: HDR0 (count low byte), HDR1 (count high byte), DATA, DONE, ERROR.
- HDR0 -> HDR1 on accept. Byte 0 is latched as count[7:0].
- HDR1 -> DATA on accept when 1 <= N <= 2^ADDR_W.
- HDR1 -> DONE on accept when N == 0.
- HDR1 -> ERROR on accept when N > 2^ADDR_W.
- DATA: a 2-bit byte lane counter shifts accepted bytes into a word buffer. Accepting lane 3 completes a word, increments words_loaded and triggers the write.
- DATA -> DONE when the N-th word completes.
- DONE: in_ready=0 and core_reset=0. A reload pulse moves to HDR0 and clears words_loaded and the lane counter. The next cycle raises core_reset.
- reload is ignored in HDR0, HDR1, DATA and ERROR. Only reset leaves ERROR.
- ERROR: in_ready=0, core_reset=1, load_error=1. No further writes occur.
- in_ready = 1 exactly in HDR0, HDR1 and DATA. There is no backpressure inside those states.
- Word address of word k is k, counting from 0. imem_addr never wraps, because N is bounded by the range check.
- reset from any state returns to HDR0 and aborts any partial word. No write is issued for the aborted word.

## Timing
- Reset values: state=HDR0, in_ready=1 in the first cycle after reset, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_error=0, words_loaded=0.
- Write latency: imem_we is high for exactly the one cycle after the lane-3 accept. imem_addr and imem_wdata are registered and valid in that same cycle.
- Back-to-back words at full rate give at most one write every 4 cycles. Writes never overlap.
- Entry into DONE from DATA happens on the lane-3 accept edge of word N, so in_ready=0 in the next cycle. In that same cycle imem_we=1 for the final word, load_done=1 and core_reset=0. The core therefore leaves reset one cycle after the final write edge.
- N==0: the cycle after the HDR1 accept shows load_done=1, core_reset=0, with no write.
- After reload, core_reset=1 and in_ready=1 one cycle after the pulse.
- reset is asserted while imem_we is pending: reset wins and imem_we=0 in the next cycle.
- Idle cycles (in_valid=0) inside a word preserve the lane counter and buffer.

## Test plan
- Program load: stream 02 00 13 05 10 00 93 05 20 00.
  - Required: writes (addr 0, 0x00100513) then (addr 1, 0x00200593), each with a one-cycle imem_we.
  - Then: words_loaded=2, load_done=1, core_reset falls in the cycle of the second write.
- Gapped input: the same stream with in_valid toggled randomly. Required: identical writes and data, with no extra or missing strobes.
- Empty program: 00 00. Required: DONE after 2 accepts, no imem_we, core_reset=0.
- Oversize: count 0x0401 with ADDR_W=10. Required: load_error=1, in_ready=0, core_reset held 1, no writes. A reload pulse has no effect; only reset recovers.
- Mid-load reset: assert reset after 6 data bytes of a 3-word program. Required: one write only (word 0), all outputs return to reset values, and a fresh full stream then loads correctly from addr 0.
- Reload: after a completed load, pulse reload and send a 1-word program 0x00000073.
  - Required: core_reset is 1 the cycle after the pulse and words_loaded=0.
  - Then: a single write of addr 0 with data 0x00000073, and the core is released again.
